// File: rtl/evt_stat_cnt_pkg.sv
// ============================================================================
// Module : evt_stat_cnt_pkg
// Brief  : Register map offsets, width constants and read-select decode for
//          the event statistics counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef DELAY
`define DELAY
`endif

package evt_stat_cnt_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 2 * DATA_WIDTH_DEF;

    localparam int REG_OFF_LO   = 0;
    localparam int REG_OFF_HI   = 1;
    localparam int REG_OFF_STAT = 2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LO   = 2'd1,
        SEL_HI   = 2'd2,
        SEL_STAT = 2'd3
    } rd_sel_e;

    function automatic rd_sel_e reg_sel(input logic rd_en,
                                        input logic hit_lo,
                                        input logic hit_hi,
                                        input logic hit_stat);
        rd_sel_e sel;
        sel = SEL_NONE;
        if (rd_en) begin
            if (hit_lo)        sel = SEL_LO;
            else if (hit_hi)   sel = SEL_HI;
            else if (hit_stat) sel = SEL_STAT;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/evt_stat_cnt_sat_cnt.sv
// ============================================================================
// Module : sat_cnt
// Brief  : Saturating up-counter with synchronous clear and sticky sat flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_cnt
    import evt_stat_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_sat
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             sat_q;
    logic             sat_d;

    // An event coincident with a clear is counted in the new period.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = {{(WIDTH-1){1'b0}}, i_inc};
        end else if (i_inc && !(&cnt_q)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        sat_d = (sat_q & ~i_clr) | (&cnt_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= `DELAY '0;
            sat_q <= `DELAY 1'b0;
        end else begin
            cnt_q <= `DELAY cnt_d;
            sat_q <= `DELAY sat_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_sat = sat_q;

endmodule

`default_nettype wire

// File: rtl/evt_stat_cnt.sv
// ============================================================================
// Module : evt_stat_cnt
// Brief  : Event counter with coherent low/high register readout and status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module evt_stat_cnt
    import evt_stat_cnt_pkg::*;
#(
    parameter int unsigned CNT_ADDR   = 10'h0,
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int          CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int          DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_evt,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd_en,
    input  logic                  i_cnt_clr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_vld,
    output logic                  o_sat
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LO   = ADDR_WIDTH'(CNT_ADDR + REG_OFF_LO);
    localparam logic [ADDR_WIDTH-1:0] ADDR_HI   = ADDR_WIDTH'(CNT_ADDR + REG_OFF_HI);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = ADDR_WIDTH'(CNT_ADDR + REG_OFF_STAT);

    logic [CNT_WIDTH-1:0]  cnt;
    logic                  sat;
    rd_sel_e               rd_sel;

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  rd_vld_q;
    logic                  rd_vld_d;
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] shadow_d;

    sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (i_evt),
        .o_cnt (cnt),
        .o_sat (sat)
    );

    assign rd_sel = reg_sel(i_rd_en, (i_addr == ADDR_LO), (i_addr == ADDR_HI),
                            (i_addr == ADDR_STAT));

    // Low-half read also freezes the high half so the pair is coherent.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        shadow_d  = shadow_q;
        unique case (rd_sel)
            SEL_LO: begin
                rd_data_d = cnt[DATA_WIDTH-1:0];
                shadow_d  = cnt[CNT_WIDTH-1:DATA_WIDTH];
                rd_vld_d  = 1'b1;
            end
            SEL_HI: begin
                rd_data_d = shadow_q;
                rd_vld_d  = 1'b1;
            end
            SEL_STAT: begin
                rd_data_d = {{(DATA_WIDTH-1){1'b0}}, sat};
                rd_vld_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q <= `DELAY '0;
            rd_vld_q  <= `DELAY 1'b0;
            shadow_q  <= `DELAY '0;
        end else begin
            rd_data_q <= `DELAY rd_data_d;
            rd_vld_q  <= `DELAY rd_vld_d;
            shadow_q  <= `DELAY shadow_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_rd_vld  = rd_vld_q;
    assign o_sat     = sat;

endmodule

`default_nettype wire

// File: tb/tb_evt_stat_cnt.sv
// ============================================================================
// Module : tb_evt_stat_cnt
// Brief  : Scoreboard bench for evt_stat_cnt with directed read/event vectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_evt_stat_cnt;

    localparam logic [9:0] A_LO   = 10'h000;
    localparam logic [9:0] A_HI   = 10'h001;
    localparam logic [9:0] A_STAT = 10'h002;
    localparam logic [9:0] A_OFF  = 10'h005;

    logic        clk = 1'b0;
    logic        rst;
    logic        evt;
    logic [9:0]  addr;
    logic        rd_en;
    logic        cnt_clr;
    logic [15:0] rd_data;
    logic        rd_vld;
    logic        sat;

    typedef struct {
        logic [15:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    evt_stat_cnt #(
        .CNT_ADDR   (10'h0),
        .ADDR_WIDTH (10),
        .CNT_WIDTH  (32),
        .DATA_WIDTH (16)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_evt     (evt),
        .i_addr    (addr),
        .i_rd_en   (rd_en),
        .i_cnt_clr (cnt_clr),
        .o_rd_data (rd_data),
        .o_rd_vld  (rd_vld),
        .o_sat     (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    // Monitor: every expected read must appear exactly one cycle after issue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            n_tests++;
            if (!rd_vld) begin
                n_fail++;
                $display("FAIL %s: rd_vld=0 at cycle %0d, required 1 (data %h)",
                         e.name, cyc_cnt, e.data);
            end else if (rd_data !== e.data) begin
                n_fail++;
                $display("FAIL %s: rd_data=%h, required %h", e.name, rd_data, e.data);
            end
        end else if (rd_vld === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_vld: rd_vld=1 data=%h at cycle %0d, required rd_vld=0",
                     rd_data, cyc_cnt);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One cycle of stimulus; in-block reads push their expected data.
    task automatic cyc(input logic e, input logic rd, input logic [9:0] a, input logic clr,
                       input logic [15:0] exp_data, input string name);
        exp_t x;
        @(negedge clk);
        evt     = e;
        rd_en   = rd;
        addr    = a;
        cnt_clr = clr;
        if (rd && (a == A_LO || a == A_HI || a == A_STAT)) begin
            x.data = exp_data;
            x.cyc  = cyc_cnt + 1;
            x.name = name;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, A_LO, 1'b0, 16'h0, "idle");
    endtask

    task automatic events(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, A_LO, 1'b0, 16'h0, "evt");
    endtask

    task automatic preload(input logic [31:0] v);
        idle(1);
        @(negedge clk);
        force dut.u_cnt.cnt_d = v;
        @(negedge clk);
        release dut.u_cnt.cnt_d;
    endtask

    initial begin
        rst = 1'b1; evt = 1'b0; addr = '0; rd_en = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_vld", 32'(rd_vld), 32'h0);
        check("rst_sat", 32'(sat), 32'h0);

        // Release with an event on the very first edge, 5 events total.
        @(negedge clk);
        rst = 1'b0;
        evt = 1'b1;
        events(4);
        cyc(1'b0, 1'b1, A_LO, 1'b1, 16'h0005, "r33_lo_5");
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0000, "r33_lo_0");
        cyc(1'b0, 1'b1, A_HI, 1'b0, 16'h0000, "r33_hi_0");
        cyc(1'b0, 1'b1, A_STAT, 1'b0, 16'h0000, "r33_stat_0");

        preload(32'h0001_FFFF);
        cyc(1'b0, 1'b1, A_LO, 1'b1, 16'hFFFF, "r34_lo");
        events(3);
        cyc(1'b0, 1'b1, A_HI, 1'b0, 16'h0001, "r34_hi");
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0003, "r34_cnt3");
        cyc(1'b0, 1'b1, A_HI, 1'b0, 16'h0000, "r34_hi_new");

        preload(32'hFFFF_FFFE);
        events(4);
        idle(1);
        check("r35_sat", 32'(sat), 32'h1);
        cyc(1'b0, 1'b1, A_STAT, 1'b0, 16'h0001, "r35_stat");
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'hFFFF, "r35_lo");
        cyc(1'b0, 1'b1, A_HI, 1'b0, 16'hFFFF, "r35_hi");
        cyc(1'b1, 1'b1, A_LO, 1'b1, 16'hFFFF, "r23_lo");
        cyc(1'b0, 1'b1, A_HI, 1'b0, 16'hFFFF, "r23_hi");
        cyc(1'b0, 1'b1, A_STAT, 1'b0, 16'h0000, "r23_stat");
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0001, "r23_cnt1");
        idle(1);
        check("r23_sat_clr", 32'(sat), 32'h0);

        cyc(1'b0, 1'b1, A_LO, 1'b1, 16'h0001, "r36_pre");
        events(7);
        cyc(1'b1, 1'b1, A_LO, 1'b1, 16'h0007, "r36_lo7");
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0001, "r36_cnt1");
        cyc(1'b0, 1'b1, A_STAT, 1'b0, 16'h0000, "r36_stat");

        // Clear pulse without a read.
        events(2);
        cyc(1'b0, 1'b0, A_LO, 1'b1, 16'h0, "clr_only");
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0000, "r24_cnt0");

        events(3);
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0003, "r37_pre");
        cyc(1'b0, 1'b1, A_OFF, 1'b0, 16'h0, "r37_off");
        idle(1);
        check("r37_vld", 32'(rd_vld), 32'h0);
        check("r37_hold", 32'(rd_data), 32'h0003);
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0003, "r37_cnt3");

        // Held read, clear only on the first cycle.
        cyc(1'b1, 1'b1, A_LO, 1'b1, 16'h0003, "r25_a");
        cyc(1'b1, 1'b1, A_LO, 1'b0, 16'h0001, "r25_b");
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0002, "r25_c");

        events(7);
        @(negedge clk);
        evt = 1'b0; rd_en = 1'b1; addr = A_LO; cnt_clr = 1'b0;
        rst = 1'b1;
        #1;
        check("r38_vld", 32'(rd_vld), 32'h0);
        check("r38_data", 32'(rd_data), 32'h0);
        check("r38_sat", 32'(sat), 32'h0);
        @(negedge clk);
        check("r38_vld_hold", 32'(rd_vld), 32'h0);
        rd_en = 1'b0;
        rst = 1'b0;
        cyc(1'b0, 1'b1, A_LO, 1'b0, 16'h0000, "r38_lo");
        cyc(1'b0, 1'b1, A_HI, 1'b0, 16'h0000, "r38_hi");
        idle(3);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
